// File: rtl/button_ctrl.sv
// Multi-button input controller.
// One prescaler tick is shared by all buttons. Each button is synchronised and
// debounced in tick units, and then drives a press / long-press / auto-repeat
// sequencer. All event outputs are registered one-cycle pulses.
module button_ctrl #(
  parameter int BTN_CNT    = 4,
  parameter int TICK_DIV   = 100000,
  parameter int DB_TICKS   = 5,
  parameter int HOLD_TICKS = 500,
  parameter int RPT_TICKS  = 100,
  parameter bit ACT_LOW    = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BTN_CNT-1:0] btn_in,
  output logic [BTN_CNT-1:0] btn,
  output logic [BTN_CNT-1:0] ondn,
  output logic [BTN_CNT-1:0] onup,
  output logic [BTN_CNT-1:0] hold,
  output logic [BTN_CNT-1:0] rpt,
  output logic               tick
);

  localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DB_W  = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
  localparam int H_MAX = (HOLD_TICKS > RPT_TICKS) ? HOLD_TICKS : RPT_TICKS;
  localparam int H_W   = (H_MAX > 1) ? $clog2(H_MAX) : 1;

  localparam logic [PS_W-1:0] PS_LAST   = PS_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_TICKS - 1);
  localparam logic [H_W-1:0]  HOLD_LAST = H_W'(HOLD_TICKS - 1);
  localparam logic [H_W-1:0]  RPT_LAST  = H_W'(RPT_TICKS - 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_HOLD = 2'd1;
  localparam logic [1:0] ST_REPEAT    = 2'd2;

  logic [PS_W-1:0]    ps_cnt;
  logic [BTN_CNT-1:0] sync_p0;
  logic [BTN_CNT-1:0] sync_p1;
  logic [BTN_CNT-1:0] s;

  // Shared prescaler: wraps every TICK_DIV cycles, tick is the registered wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_cnt <= '0;
      tick   <= 1'b0;
    end else begin
      tick <= (ps_cnt == PS_LAST);
      if (ps_cnt == PS_LAST) ps_cnt <= '0;
      else                   ps_cnt <= ps_cnt + PS_W'(1);
    end
  end

  // Two-flop synchroniser for the raw asynchronous inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_in;
      sync_p1 <= sync_p0;
    end
  end

  // Polarity is normalised after synchronisation so downstream logic is active-high.
  assign s = sync_p1 ^ {BTN_CNT{ACT_LOW}};

  for (genvar i = 0; i < BTN_CNT; i++) begin : g_btn
    logic [DB_W-1:0] db_cnt;
    logic [H_W-1:0]  h_cnt;
    logic [1:0]      state;
    logic            btn_r;
    logic            ondn_r;
    logic            onup_r;
    logic            hold_r;
    logic            rpt_r;
    logic            accept;
    logic            rise;
    logic            fall;

    // A new level is accepted on the tick that completes DB_TICKS mismatched ticks.
    assign accept = tick && (s[i] != btn_r) && (db_cnt == DB_LAST);
    assign rise   = accept &  s[i];
    assign fall   = accept & ~s[i];

    // Debounce counter, debounced level and press/release pulses.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        db_cnt <= '0;
        btn_r  <= 1'b0;
        ondn_r <= 1'b0;
        onup_r <= 1'b0;
      end else begin
        ondn_r <= rise;
        onup_r <= fall;
        if (s[i] == btn_r) begin
          db_cnt <= '0;
        end else if (tick) begin
          if (db_cnt == DB_LAST) begin
            btn_r  <= ~btn_r;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
      end
    end

    // Press/hold/repeat sequencer; an accepted release overrides any expiry.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state  <= ST_IDLE;
        h_cnt  <= '0;
        hold_r <= 1'b0;
        rpt_r  <= 1'b0;
      end else begin
        hold_r <= 1'b0;
        rpt_r  <= 1'b0;
        if (fall) begin
          state <= ST_IDLE;
          h_cnt <= '0;
        end else begin
          case (state)
            ST_IDLE: begin
              if (rise) begin
                state <= ST_WAIT_HOLD;
                h_cnt <= '0;
              end
            end
            ST_WAIT_HOLD: begin
              if (tick) begin
                if (h_cnt == HOLD_LAST) begin
                  hold_r <= 1'b1;
                  h_cnt  <= '0;
                  state  <= ST_REPEAT;
                end else begin
                  h_cnt <= h_cnt + H_W'(1);
                end
              end
            end
            ST_REPEAT: begin
              if (tick) begin
                if (h_cnt == RPT_LAST) begin
                  rpt_r <= 1'b1;
                  h_cnt <= '0;
                end else begin
                  h_cnt <= h_cnt + H_W'(1);
                end
              end
            end
            default: begin
              state <= ST_IDLE;
              h_cnt <= '0;
            end
          endcase
        end
      end
    end

    assign btn[i]  = btn_r;
    assign ondn[i] = ondn_r;
    assign onup[i] = onup_r;
    assign hold[i] = hold_r;
    assign rpt[i]  = rpt_r;
  end

endmodule

// File: tb/tb_button_ctrl.sv
// Bench for button_ctrl: an active-high and an active-low instance share one
// stimulus (the second sees it inverted) and are compared every cycle against a
// tick-counting reference model, plus directed latency and event-spacing checks.
module tb_button_ctrl;
  localparam int N  = 2;
  localparam int TD = 4;
  localparam int DB = 3;
  localparam int HT = 5;
  localparam int RT = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_in_al;
  logic [N-1:0] btn, ondn, onup, hold, rpt;
  logic         tick;
  logic [N-1:0] btn_a, ondn_a, onup_a, hold_a, rpt_a;
  logic         tick_a;

  assign btn_in_al = ~btn_in;

  always #5 clk = ~clk;

  button_ctrl #(.BTN_CNT(N), .TICK_DIV(TD), .DB_TICKS(DB), .HOLD_TICKS(HT),
                .RPT_TICKS(RT), .ACT_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .btn(btn), .ondn(ondn),
    .onup(onup), .hold(hold), .rpt(rpt), .tick(tick));

  button_ctrl #(.BTN_CNT(N), .TICK_DIV(TD), .DB_TICKS(DB), .HOLD_TICKS(HT),
                .RPT_TICKS(RT), .ACT_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .btn_in(btn_in_al), .btn(btn_a), .ondn(ondn_a),
    .onup(onup_a), .hold(hold_a), .rpt(rpt_a), .tick(tick_a));

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: edge count since reset, sync pipeline, and per
  // button the run of mismatched ticks and the ticks elapsed since the press.
  int           n_edge;
  logic         m_tick;
  logic [N-1:0] m_s1, m_s2, m_btn, m_ondn, m_onup, m_hold, m_rpt;
  int           mis   [N];
  int           press [N];

  int n_ondn0, n_onup0, n_hold0, n_rpt0;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    compared++;
    assert (obs >= lo && obs <= hi) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic model_reset();
    n_edge = 0;
    m_tick = 1'b0;
    m_s1 = '0; m_s2 = '0; m_btn = '0;
    m_ondn = '0; m_onup = '0; m_hold = '0; m_rpt = '0;
    for (int i = 0; i < N; i++) begin
      mis[i]   = 0;
      press[i] = 0;
    end
  endtask

  task automatic model_edge();
    logic         tick_now;
    logic [N-1:0] s_now;
    tick_now = m_tick;
    s_now    = m_s2;
    m_ondn = '0; m_onup = '0; m_hold = '0; m_rpt = '0;
    for (int i = 0; i < N; i++) begin
      if (s_now[i] == m_btn[i]) begin
        mis[i] = 0;
      end else if (tick_now) begin
        mis[i]++;
        if (mis[i] == DB) begin
          mis[i]   = 0;
          m_btn[i] = s_now[i];
          if (s_now[i]) m_ondn[i] = 1'b1;
          else          m_onup[i] = 1'b1;
        end
      end
      if (m_onup[i] || m_ondn[i]) begin
        press[i] = 0;
      end else if (m_btn[i] && tick_now) begin
        press[i]++;
        if (press[i] == HT) m_hold[i] = 1'b1;
        else if (press[i] > HT && (press[i] - HT) % RT == 0) m_rpt[i] = 1'b1;
      end
    end
    m_s2 = m_s1;
    m_s1 = btn_in;
    n_edge++;
    m_tick = (n_edge % TD == 0);
  endtask

  task automatic check_all();
    chk("btn",  btn,  m_btn);
    chk("ondn", ondn, m_ondn);
    chk("onup", onup, m_onup);
    chk("hold", hold, m_hold);
    chk("rpt",  rpt,  m_rpt);
    chk("tick", N'(tick), N'(m_tick));
    chk("al_btn",  btn_a,  m_btn);
    chk("al_ondn", ondn_a, m_ondn);
    chk("al_onup", onup_a, m_onup);
    chk("al_hold", hold_a, m_hold);
    chk("al_rpt",  rpt_a,  m_rpt);
    chk("al_tick", N'(tick_a), N'(m_tick));
    chk("excl", (ondn & onup) | (ondn & hold) | (ondn & rpt) |
                (onup & hold) | (onup & rpt) | (hold & rpt), '0);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    @(negedge clk);
    check_all();
    if (ondn[0]) n_ondn0++;
    if (onup[0]) n_onup0++;
    if (hold[0]) n_hold0++;
    if (rpt[0])  n_rpt0++;
  endtask

  task automatic clear_counts();
    n_ondn0 = 0; n_onup0 = 0; n_hold0 = 0; n_rpt0 = 0;
  endtask

  initial begin
    int k;
    int d;
    rst    = 1'b1;
    btn_in = '0;
    model_reset();
    clear_counts();
    repeat (3) step();
    chk("reset_btn", btn, '0);
    chk("reset_evt", ondn | onup | hold | rpt, '0);
    rst = 1'b0;
    repeat (10) step();

    // Short glitches on button 0 never reach the debounced level.
    for (int g = 0; g < 3; g++) begin
      clear_counts();
      btn_in[0] = 1'b1;
      repeat ($urandom_range(1, 6)) step();
      btn_in[0] = 1'b0;
      repeat (30) step();
      chk("glitch_btn", btn, '0);
      chk_rng("glitch_evt", n_ondn0 + n_onup0, 0, 0);
    end

    // Press for 40 cycles, then release.
    clear_counts();
    btn_in[0] = 1'b1;
    k = 0;
    do begin step(); k++; end while (!ondn[0] && k < 30);
    chk_rng("press_lat", k, 11, 14);
    repeat (40 - k) step();
    btn_in[0] = 1'b0;
    k = 0;
    do begin step(); k++; end while (!onup[0] && k < 30);
    chk_rng("release_lat", k, 11, 14);
    chk_rng("press_ondn_cnt", n_ondn0, 1, 1);
    chk_rng("press_onup_cnt", n_onup0, 1, 1);
    chk("press_btn1", N'(btn[1]), '0);
    repeat (20) step();

    // Long press: hold 20 cycles after ondn, then a repeat every 8 cycles.
    clear_counts();
    btn_in[0] = 1'b1;
    k = 0;
    do begin step(); k++; end while (!ondn[0] && k < 30);
    chk_rng("long_lat", k, 11, 14);
    d = 0;
    do begin step(); d++; end while (!hold[0] && d < 40);
    chk_rng("hold_dist", d, 20, 20);
    for (int r = 0; r < 4; r++) begin
      d = 0;
      do begin step(); d++; end while (!rpt[0] && d < 20);
      chk_rng("rpt_dist", d, 8, 8);
    end
    chk_rng("rpt_cnt", n_rpt0, 4, 4);
    btn_in[0] = 1'b0;
    k = 0;
    do begin step(); k++; end while (!onup[0] && k < 30);
    chk_rng("long_rel_lat", k, 11, 14);
    repeat (20) step();

    // Release acceptance lands on the hold-expiry tick: only onup fires.
    clear_counts();
    btn_in[0] = 1'b1;
    k = 0;
    do begin step(); k++; end while (!ondn[0] && k < 30);
    chk_rng("race_lat", k, 11, 14);
    repeat (7) step();
    btn_in[0] = 1'b0;
    d = 7;
    do begin step(); d++; end while (!onup[0] && d < 40);
    chk_rng("race_onup_dist", d, 20, 20);
    repeat (30) step();
    chk_rng("race_no_hold", n_hold0 + n_rpt0, 0, 0);
    chk("race_btn", btn, '0);

    // Random traffic on both buttons against the model.
    for (int seg = 0; seg < 40; seg++) begin
      btn_in = N'($urandom_range(0, 3));
      repeat ($urandom_range(1, 60)) step();
    end

    // Reset while both buttons are held; they must re-debounce afterwards.
    btn_in = 2'b11;
    repeat (30) step();
    rst = 1'b1;
    #1;
    chk("async_rst_btn", btn | btn_a, '0);
    chk("async_rst_evt", ondn | onup | hold | rpt | ondn_a | onup_a | hold_a | rpt_a, '0);
    chk("async_rst_tick", N'(tick | tick_a), '0);
    model_reset();
    repeat (3) step();
    rst = 1'b0;
    k = 0;
    do begin step(); k++; end while (btn != 2'b11 && k < 20);
    chk_rng("rst_relat", k, 1, 14);
    chk("rst_ondn", ondn, 2'b11);
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
